// File: rtl/reg_cmd_driver.sv
// reg_cmd_driver: accepts load / increment-burst / clear commands and turns
// them into registered, mutually exclusive strobes for an external 12-bit
// register. It also keeps a shadow copy of the value the register should hold.
// Optional build macro: REG_CMD_DRIVER_READBACK_CHECK_EN adds a readback
// comparator that drives err / err_cnt. When the macro is not defined, both
// outputs are tied to 0.
module reg_cmd_driver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  input  logic [11:0] cmd_count,
  output logic        load,
  output logic        inc,
  output logic        clr,
  output logic [15:0] indata,
  input  logic [11:0] reg_out,
  output logic [11:0] shadow,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CLR  = 3'd2,
    S_INC  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [15:0] indata_q, indata_d;
  logic [11:0] shadow_q, shadow_d;
  logic        load_q, load_d;
  logic        inc_q, inc_d;
  logic        clr_q, clr_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        accept_s;

  // ready_q is 0 during reset and only goes to 1 in IDLE, so it also gates accept
  assign accept_s = cmd_valid & ready_q;

  // Next-state, latched-command and shadow computation; strobes decoded from the next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    indata_d = indata_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            2'b01: begin
              state_d  = S_LOAD;
              indata_d = cmd_data;
              shadow_d = cmd_data[11:0];
            end
            2'b11: begin
              state_d  = S_CLR;
              shadow_d = 12'd0;
            end
            2'b10: begin
              if (cmd_count != 12'd0) begin
                state_d  = S_INC;
                cnt_d    = cmd_count;
                shadow_d = shadow_q + 12'd1;
              end else begin
                state_d  = S_DONE;
              end
            end
            default: state_d = S_DONE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: state_d = S_DONE;
      S_CLR:  state_d = S_DONE;
      S_INC: begin
        // cnt_q holds the number of pulses still owed, including the current one
        if (cnt_q == 12'd1) begin
          state_d = S_DONE;
        end else begin
          cnt_d    = cnt_q - 12'd1;
          shadow_d = shadow_q + 12'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    load_d  = (state_d == S_LOAD);
    inc_d   = (state_d == S_INC);
    clr_d   = (state_d == S_CLR);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  // State, command latches and registered Moore outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 12'd0;
      indata_q <= 16'd0;
      shadow_q <= 12'd0;
      load_q   <= 1'b0;
      inc_q    <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      indata_q <= indata_d;
      shadow_q <= shadow_d;
      load_q   <= load_d;
      inc_q    <= inc_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign load      = load_q;
  assign inc       = inc_q;
  assign clr       = clr_q;
  assign indata    = indata_q;
  assign shadow    = shadow_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef REG_CMD_DRIVER_READBACK_CHECK_EN
  logic        pend_q, pend_d;
  logic        armed_q, armed_d;
  logic        err_q, err_d;
  logic [11:0] chk_q, chk_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        mismatch_s;

  // Readback compare: reg_out in the cycle after a strobe must match the shadow of the strobe cycle
  always_comb begin
    pend_d     = load_q | inc_q | clr_q;
    chk_d      = shadow_q;
    armed_d    = armed_q | load_q | clr_q;
    mismatch_s = pend_q & armed_q & (reg_out != chk_q);
    err_d      = err_q | mismatch_s;
    if (mismatch_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Comparator state; the check stays disarmed until the register has a known value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      armed_q   <= 1'b0;
      err_q     <= 1'b0;
      chk_q     <= 12'd0;
      err_cnt_q <= 8'd0;
    end else begin
      pend_q    <= pend_d;
      armed_q   <= armed_d;
      err_q     <= err_d;
      chk_q     <= chk_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_readback;
  assign unused_readback = ^reg_out;
  assign err             = 1'b0;
  assign err_cnt         = 8'd0;
`endif

endmodule

// File: tb/tb_reg_cmd_driver.sv
// Self-checking bench for reg_cmd_driver. The bench has three parts:
// - A command-level reference model. It expands each accepted command into a
//   queue of per-cycle expected outputs.
// - A simple register that responds to the strobes.
// - A compare process that runs on every falling edge.
// It also contains directed literal checks and a long random phase.
module tb_reg_cmd_driver;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [11:0] cmd_count;
  logic        load, inc, clr;
  logic [15:0] indata;
  logic [11:0] reg_out;
  logic [11:0] shadow;
  logic        busy, done, err;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef REG_CMD_DRIVER_READBACK_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  reg_cmd_driver dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .load(load), .inc(inc), .clr(clr), .indata(indata), .reg_out(reg_out),
    .shadow(shadow), .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External 12-bit register. It starts from an arbitrary value and can be
  // overridden by a forced readback value.
  logic [11:0] reg_q = 12'h5A5;
  logic        force_en = 1'b0;
  logic [11:0] force_val = 12'h000;
  always @(posedge clk) begin
    if (load)     reg_q <= indata[11:0];
    else if (clr) reg_q <= 12'h000;
    else if (inc) reg_q <= reg_q + 12'h001;
  end
  assign reg_out = force_en ? force_val : reg_q;

  typedef struct packed {
    logic        load, inc, clr, done, busy, ready;
    logic [15:0] indata;
    logic [11:0] shadow;
  } exp_t;

  exp_t        q[$];
  exp_t        cur, prev;
  logic [11:0] m_sh;
  logic [15:0] m_ind;
  bit          armed_c;
  logic        m_err;
  int          m_cnt;
  bit          started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expand one accepted command into its cycle-by-cycle expected outputs
  task automatic push_cmd(input logic [1:0] op, input logic [15:0] d, input logic [11:0] c);
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    case (op)
      2'b01: begin
        m_ind = d; m_sh = d[11:0];
        e.load = 1'b1; e.indata = m_ind; e.shadow = m_sh; q.push_back(e);
      end
      2'b11: begin
        m_sh = 12'h000;
        e.clr = 1'b1; e.indata = m_ind; e.shadow = m_sh; q.push_back(e);
      end
      2'b10: begin
        for (int k = 0; k < int'(c); k++) begin
          m_sh = m_sh + 12'h001;
          e.inc = 1'b1; e.indata = m_ind; e.shadow = m_sh; q.push_back(e);
        end
      end
      default: ;
    endcase
    e = '0;
    e.busy = 1'b1; e.done = 1'b1; e.indata = m_ind; e.shadow = m_sh;
    q.push_back(e);
  endtask

  // Reference model: step once per rising edge
  initial begin
    exp_t idle;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        m_sh = 12'h000; m_ind = 16'h0000;
        cur = '0; prev = '0;
        armed_c = 1'b0; m_err = 1'b0; m_cnt = 0;
        started = 1'b1;
      end else begin
        if (CHECK_EN && armed_c && (prev.load || prev.inc || prev.clr) && (reg_out != prev.shadow)) begin
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
        if (cmd_valid && cur.ready) push_cmd(cmd_op, cmd_data, cmd_count);
        prev = cur;
        if (q.size() > 0) begin
          cur = q.pop_front();
        end else begin
          idle = '0; idle.ready = 1'b1; idle.indata = m_ind; idle.shadow = m_sh;
          cur = idle;
        end
        armed_c = armed_c | prev.load | prev.clr;
      end
    end
  end

  // Compare process: check every DUT output against the model on each falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cmd_ready", cmd_ready, cur.ready);
        chk("busy", busy, cur.busy);
        chk("done", done, cur.done);
        chk("load", load, cur.load);
        chk("inc", inc, cur.inc);
        chk("clr", clr, cur.clr);
        chk("indata", indata, cur.indata);
        chk("shadow", shadow, cur.shadow);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_cnt);
        chk("strobe_excl", ((32'(load) + 32'(inc) + 32'(clr)) <= 32'd1), 32'd1);
        if (armed_c && !force_en) chk("reg_vs_shadow", reg_out, prev.shadow);
      end
    end
  end

  // Issue one command at a falling edge. Returns at the falling edge of the
  // cycle that follows the accept.
  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [11:0] c);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      failures++;
      $display("FAIL send_timeout actual=ready_low expected=ready_high t=%0t", $time);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = 16'($urandom);
    cmd_count = 12'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 16'h0000; cmd_count = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Load 16'hABCD
    send(2'b01, 16'hABCD, 12'h000);
    chk("pin_load", load, 1'b1);
    chk("pin_indata", indata, 16'hABCD);
    chk("pin_shadow_bcd", shadow, 12'hBCD);
    @(negedge clk);
    chk("pin_load_done", done, 1'b1);
    chk("pin_load_off", load, 1'b0);
    @(negedge clk);
    chk("pin_ready_back", cmd_ready, 1'b1);

    // Load 12'hFFE, then an increment burst of 3 that wraps
    send(2'b01, 16'h0FFE, 12'h000);
    send(2'b10, 16'h1234, 12'd3);
    chk("pin_inc1", inc, 1'b1);
    chk("pin_sh_fff", shadow, 12'hFFF);
    @(negedge clk);
    chk("pin_inc2", inc, 1'b1);
    chk("pin_sh_000", shadow, 12'h000);
    @(negedge clk);
    chk("pin_inc3", inc, 1'b1);
    chk("pin_sh_001", shadow, 12'h001);
    @(negedge clk);
    chk("pin_inc_end", inc, 1'b0);
    chk("pin_inc_done", done, 1'b1);
    @(negedge clk);
    chk("pin_no_err", err, 1'b0);

    // Increment burst with count 0
    send(2'b10, 16'h0000, 12'd0);
    chk("pin_c0_done", done, 1'b1);
    chk("pin_c0_noinc", inc, 1'b0);
    @(negedge clk);
    chk("pin_c0_ready", cmd_ready, 1'b1);

    // Forced readback mismatches
    force_en = 1'b1; force_val = 12'h001;
    send(2'b11, 16'h0000, 12'h000);
    repeat (2) @(negedge clk);
    chk("pin_err_one", err, CHECK_EN ? 1'b1 : 1'b0);
    chk("pin_err_cnt_one", err_cnt, CHECK_EN ? 8'd1 : 8'd0);
    force_val = 12'hFFF;
    send(2'b10, 16'h0000, 12'd300);
    repeat (301) @(negedge clk);
    chk("pin_err_cnt_sat", err_cnt, CHECK_EN ? 8'd255 : 8'd0);
    force_en = 1'b0;

    // Reset during an increment burst of 100, after 10 pulses
    send(2'b10, 16'h0000, 12'd100);
    chk("pin_abort_inc", inc, 1'b1);
    repeat (9) begin
      @(negedge clk);
      chk("pin_abort_inc", inc, 1'b1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("pin_abort_noinc", inc, 1'b0);
    chk("pin_abort_nodone", done, 1'b0);
    chk("pin_abort_shadow", shadow, 12'h000);
    chk("pin_abort_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pin_abort_ready", cmd_ready, 1'b1);
    chk("pin_abort_nodone2", done, 1'b0);

    // Random phase: cmd_valid held high, and the inputs change every cycle
    cmd_valid = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      cmd_op   = 2'($urandom);
      cmd_data = 16'($urandom);
      if ($urandom_range(0, 7) == 0) cmd_count = 12'd0;
      else cmd_count = 12'($urandom_range(1, 20));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
